// File: rtl/dpe_accum_requant.sv
// dpe_accum_requant: accumulates NUM_TILES DPE partial results into one neuron
// value, adds bias, applies optional ReLU, requantizes to QPREC bits with
// round-half-up and saturation, and buffers the results in a show-ahead FIFO.
module dpe_accum_requant #(
    parameter int OPREC      = 32,
    parameter int ACCW       = 40,
    parameter int NUM_TILES  = 4,
    parameter int SCALEW     = 16,
    parameter int QPREC      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic signed [OPREC-1:0]  i_result,
    input  logic signed [ACCW-1:0]   i_bias,
    input  logic        [SCALEW-1:0] i_scale,
    input  logic        [5:0]        i_shift,
    input  logic                     i_relu_en,
    output logic                     o_valid,
    output logic signed [QPREC-1:0]  o_data,
    input  logic                     i_ready,
    output logic                     o_overflow,
    output logic                     o_busy
);

    localparam int CW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int PW = ACCW + SCALEW + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic signed [PW-1:0] QMAX = {{(PW-QPREC+1){1'b0}}, {(QPREC-1){1'b1}}};
    localparam logic signed [PW-1:0] QMIN = {{(PW-QPREC+1){1'b1}}, {(QPREC-1){1'b0}}};

    // ---------------- stage A: accumulate ----------------
    logic [CW-1:0]          tile_cnt;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] res_ext;
    logic signed [ACCW-1:0] acc_sum;
    logic                   last_tile;

    logic                   b_valid;
    logic signed [ACCW-1:0] b_acc;

    // first tile of a group starts from the bias instead of the running sum
    always_comb begin
        res_ext   = ACCW'(i_result);
        acc_sum   = ((tile_cnt == '0) ? i_bias : acc) + res_ext;
        last_tile = (tile_cnt == CW'(NUM_TILES - 1));
    end

    // accumulator, tile counter and hand-off of completed sums to stage B
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile_cnt <= '0;
            acc      <= '0;
            b_valid  <= 1'b0;
            b_acc    <= '0;
        end else begin
            b_valid <= 1'b0;
            if (i_valid) begin
                acc <= acc_sum;
                if (last_tile) begin
                    tile_cnt <= '0;
                    b_valid  <= 1'b1;
                    b_acc    <= acc_sum;
                end else begin
                    tile_cnt <= tile_cnt + CW'(1);
                end
            end
        end
    end

    assign o_busy = (tile_cnt != '0);

    // ---------------- stage B: ReLU and scale ----------------
    logic signed [PW-1:0] v_ext;
    logic signed [PW-1:0] s_ext;
    logic signed [PW-1:0] prod_next;
    logic signed [PW-1:0] prod;
    logic                 c_in_valid;

    // scale is unsigned, so it is zero-extended before the signed multiply
    always_comb begin
        v_ext     = (i_relu_en && b_acc[ACCW-1]) ? '0 : PW'(b_acc);
        s_ext     = PW'({1'b0, i_scale});
        prod_next = v_ext * s_ext;
    end

    // product register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod       <= '0;
            c_in_valid <= 1'b0;
        end else begin
            prod       <= prod_next;
            c_in_valid <= b_valid;
        end
    end

    // ---------------- stage C: round, shift, saturate ----------------
    logic signed [PW-1:0]    rnd;
    logic signed [PW-1:0]    shifted;
    logic signed [QPREC-1:0] q_next;
    logic signed [QPREC-1:0] c_data;
    logic                    c_valid;

    // adding half an LSB before the arithmetic shift rounds half toward +inf
    always_comb begin
        rnd     = (i_shift == 6'd0) ? '0 : (PW'(1) << (i_shift - 6'd1));
        shifted = (prod + rnd) >>> i_shift;
        if (shifted > QMAX)
            q_next = QMAX[QPREC-1:0];
        else if (shifted < QMIN)
            q_next = QMIN[QPREC-1:0];
        else
            q_next = shifted[QPREC-1:0];
    end

    // requantized result register feeding the FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_valid <= 1'b0;
            c_data  <= '0;
        end else begin
            c_valid <= c_in_valid;
            c_data  <= q_next;
        end
    end

    // ---------------- output FIFO ----------------
    logic [QPREC-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    // a push into a full FIFO is still accepted when a pop frees a slot
    always_comb begin
        empty   = (count == '0);
        full    = (count == (AW+1)'(FIFO_DEPTH));
        pop_ok  = i_ready && !empty;
        push_ok = c_valid && (!full || pop_ok);
    end

    // FIFO storage; contents are only observable through the valid head
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= c_data;
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (c_valid && !push_ok)
                o_overflow <= 1'b1;
        end
    end

    assign o_valid = !empty;
    assign o_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: doc/dpe_accum_requant.md
Name: dpe_accum_requant

Overview:
- Sits directly downstream of the int8 dot-product engine (DPE).
- Consumes the DPE's 32-bit signed dot-product results (valid only, no backpressure).
- Accumulates NUM_TILES consecutive results into one output neuron, adds a bias, applies optional ReLU, and requantizes to int8 by scale-multiply and rounding right-shift with saturation.
- Buffers int8 results in a small show-ahead FIFO with a valid/ready output handshake toward the next layer's input packer.

Parameters:
- OPREC, 32, width of incoming DPE result (signed)
- ACCW, 40, accumulator width (signed)
- NUM_TILES, 4, DPE results summed per output value (>=1)
- SCALEW, 16, unsigned requant multiplier width
- QPREC, 8, output precision (signed)
- FIFO_DEPTH, 4, output FIFO entries (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_valid  in  1  DPE result valid
- i_result  in  OPREC  DPE dot-product result, signed
- i_bias  in  ACCW  bias, signed; sampled on the first tile of each group
- i_scale  in  SCALEW  requant multiplier, unsigned; quasi-static
- i_shift  in  6  requant right-shift amount (0..47); quasi-static
- i_relu_en  in  1  1 = clamp negative accumulations to 0; quasi-static
- o_valid  out  1  FIFO non-empty
- o_data  out  QPREC  FIFO head, signed int8
- i_ready  in  1  downstream accepts o_data when o_valid&i_ready
- o_overflow  out  1  sticky: a result was dropped because the FIFO was full
- o_busy  out  1  partial accumulation in progress (tile count != 0)

Behaviour:
- Reset (rst=0, async): tile count=0, acc=0, all pipeline valids=0, FIFO empty. o_valid=0, o_data=0, o_overflow=0, o_busy=0.
- Stage A (accumulate), on i_valid:
  - Sign-extend i_result to ACCW.
  - If tile count==0: acc <= i_bias + ext(i_result); else acc <= acc + ext(i_result).
  - Tile count increments, wrapping to 0 after NUM_TILES-1.
  - On the wrapping (last) tile, the final sum is registered into stage B with valid=1.
  - Cycles with i_valid=0 leave acc and count unchanged; gaps within a group are legal.
  - NUM_TILES=1: every i_valid is a last tile, and bias is added every time.
  - ACCW additions wrap two's-complement (no saturation).
- Stage B (ReLU+scale):
  - v = (i_relu_en && acc<0) ? 0 : acc.
  - prod = v * {0,i_scale}, signed, ACCW+SCALEW+1 bits, registered.
- Stage C (round/saturate):
  - r = (prod + (i_shift>0 ? 1<<(i_shift-1) : 0)) >>> i_shift, arithmetic shift (round half toward +inf).
  - Saturate to [-128,127].
  - Registered, then written to the FIFO.
- Latency:
  - The last tile at cycle T is written into the FIFO at the T+3 edge.
  - o_valid and o_data reflect it from cycle T+4 when the FIFO was empty.
  - Pipeline stages never stall.
- FIFO:
  - Show-ahead: o_data = head whenever o_valid=1, and holds stable while o_valid&!i_ready.
  - Pop on o_valid&i_ready.
  - Push and pop in the same cycle are both honoured, including when full (count unchanged).
  - Push when full and no pop: value dropped, FIFO unchanged, o_overflow <= 1. o_overflow stays set until reset.
  - Pop when empty is ignored.
- o_busy = (tile count != 0). It does not cover stages B/C or FIFO occupancy.
- Config changes (i_scale, i_shift, i_relu_en) take effect on values entering stage B/C in that cycle. Software changes them only when o_busy=0 and the pipeline is drained.
- Reset mid-group discards the partial acc, in-flight stages, and FIFO contents.

Test Plan:
- NUM_TILES=4, bias=10, results 100,200,-50,40 back-to-back, scale=1, shift=0, relu=0, i_ready=1 -> one output 127 (sum 300 saturated), o_valid exactly 4 cycles after the 4th i_valid, for 1 cycle.
- bias=0, results -3,-2,-1,-1, scale=3, shift=2, relu=0 -> -5 (−21+2=−19 >>>2). Same with relu=1 -> 0.
- bias=0, results 1,2,3,0 with idle gaps of 0..3 cycles between tiles, scale=1, shift=2 -> 2 (6+2 >>2). o_busy high from the 1st tile until the 4th tile is accepted.
- i_ready=0, five groups each summing to 1 (scale=1, shift=0) -> o_valid=1 after the first, o_data stable at 1, o_overflow=1 after the 5th write. Then i_ready=1 -> exactly 4 outputs, then o_valid=0.
- FIFO full with i_ready=1 in the same cycle a new result is pushed -> no overflow, count stays 4, output order preserved.
- Assert rst low after 2 of 4 tiles, release, then feed a fresh 4-tile group (bias 0, values 5,5,5,5, scale 1) -> output 20 only, no stale output, o_overflow=0.
